// File: rtl/fwrisc_pkg.sv
// Shared constants and types for the fwrisc operand-fetch slice.
package fwrisc_pkg;

    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SB_W       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    // Per-entry stage state: LIVE reads the regfile, HELD reads the captured copy
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LIVE,
        ST_HELD
    } of_state_e;

endpackage

// File: rtl/fwrisc_opnd_hold.sv
// One operand path: regfile/held-copy select, x0 force, writeback forwarding and
// held-copy coherence with the writeback port.
module fwrisc_opnd_hold #(
    parameter int unsigned REG_ADDR_W = fwrisc_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W     = fwrisc_pkg::DATA_W,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic                  i_held,
    input  logic                  i_capture,
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic                  i_wb_wen,
    input  logic [REG_ADDR_W-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0]     i_wb_wdata,
    output logic [DATA_W-1:0]     o_data
);

    logic                  w_zero;
    logic                  w_wb_hit;
    logic                  w_fwd;
    logic [DATA_W-1:0]     w_src;
    logic [DATA_W-1:0]     r_data;

    assign w_zero   = (i_addr == '0);
    assign w_wb_hit = i_wb_wen && (i_wb_waddr == i_addr) && !w_zero;
    assign w_fwd    = BYPASS_EN && w_wb_hit;
    assign w_src    = i_held ? r_data : i_rdata;

    always_comb begin
        o_data = '0;
        if (i_valid && !w_zero) begin
            o_data = w_fwd ? i_wb_wdata : w_src;
        end
    end

    // A matching writeback always lands in the held copy, even without forwarding,
    // so the copy never goes stale relative to the register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
        end else if ((i_capture || i_held) && w_wb_hit) begin
            r_data <= i_wb_wdata;
        end else if (i_capture) begin
            r_data <= w_zero ? '0 : i_rdata;
        end
    end

endmodule

// File: rtl/fwrisc_operand_fetch.sv
// Operand-fetch stage: single-entry valid/ready buffer between decode and execute,
// driving regfile read addresses and presenting forwarded rs1/rs2 operands.
module fwrisc_operand_fetch #(
    parameter int unsigned REG_ADDR_W = fwrisc_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W     = fwrisc_pkg::DATA_W,
    parameter int unsigned SB_W       = fwrisc_pkg::SB_W,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_ra,
    input  logic [REG_ADDR_W-1:0] in_rb,
    input  logic [SB_W-1:0]       in_sb,
    output logic [REG_ADDR_W-1:0] ra_raddr,
    input  logic [DATA_W-1:0]     ra_rdata,
    output logic [REG_ADDR_W-1:0] rb_raddr,
    input  logic [DATA_W-1:0]     rb_rdata,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_ra_data,
    output logic [DATA_W-1:0]     out_rb_data,
    output logic [SB_W-1:0]       out_sb
);

    import fwrisc_pkg::*;

    of_state_e             r_state;
    of_state_e             w_state_nxt;
    logic [REG_ADDR_W-1:0] r_ra;
    logic [REG_ADDR_W-1:0] r_rb;
    logic [SB_W-1:0]       r_sb;
    logic                  w_valid;
    logic                  w_held;
    logic                  w_accept;
    logic                  w_capture;

    assign w_valid   = (r_state != ST_EMPTY);
    assign w_held    = (r_state == ST_HELD);
    // in_ready intentionally depends on out_ready; out_valid is purely registered
    assign in_ready  = !reset && !flush && (!w_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == ST_LIVE) && !out_ready && !reset && !flush;

    assign ra_raddr  = w_accept ? in_ra : r_ra;
    assign rb_raddr  = w_accept ? in_rb : r_rb;
    assign out_valid = w_valid;
    assign out_sb    = w_valid ? r_sb : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_LIVE;
        end else if (w_valid && out_ready) begin
            w_state_nxt = ST_EMPTY;
        end else if (r_state == ST_LIVE) begin
            w_state_nxt = ST_HELD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ra <= '0;
            r_rb <= '0;
            r_sb <= '0;
        end else if (w_accept) begin
            r_ra <= in_ra;
            r_rb <= in_rb;
            r_sb <= in_sb;
        end
    end

    fwrisc_opnd_hold #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W),
        .BYPASS_EN  (BYPASS_EN)
    ) u_ra (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (w_valid),
        .i_held     (w_held),
        .i_capture  (w_capture),
        .i_addr     (r_ra),
        .i_rdata    (ra_rdata),
        .i_wb_wen   (wb_wen),
        .i_wb_waddr (wb_waddr),
        .i_wb_wdata (wb_wdata),
        .o_data     (out_ra_data)
    );

    fwrisc_opnd_hold #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W),
        .BYPASS_EN  (BYPASS_EN)
    ) u_rb (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (w_valid),
        .i_held     (w_held),
        .i_capture  (w_capture),
        .i_addr     (r_rb),
        .i_rdata    (rb_rdata),
        .i_wb_wen   (wb_wen),
        .i_wb_waddr (wb_waddr),
        .i_wb_wdata (wb_wdata),
        .o_data     (out_rb_data)
    );

endmodule
